// File: rtl/zbt_read_prefetch.sv
// ZBT read prefetch: issues ring-buffer reads, hides SRAM latency in a
// word FIFO and presents a byte-advancing 32-bit window to the parser.
module zbt_read_prefetch #(
    parameter int ADDR_WIDTH   = 19,
    parameter int FIFO_LOG2    = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ZBT_Reset_Address_I,
    input  logic                  ZBT_Busy_I,
    output logic [ADDR_WIDTH-1:0] ZBT_Address_O,
    input  logic [31:0]           ZBT_Data_I,
    input  logic                  Shift_8_En_I,
    output logic                  Buffer_Empty_O,
    output logic [31:0]           Bitstream_Data_O,
    output logic [FIFO_LOG2:0]    Word_Count_O
);

    localparam int DEPTH = 1 << FIFO_LOG2;

    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             mem_q [DEPTH];
    logic [FIFO_LOG2-1:0]    wptr_q, wptr_d;
    logic [FIFO_LOG2-1:0]    rptr_q, rptr_d;
    logic [FIFO_LOG2:0]      cnt_q, cnt_d;
    logic [63:0]             win_q, win_d;
    logic [3:0]              c_q, c_d;
    logic                    empty_q;

    int                      inflight;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    shift;
    logic                    fifo_full;
    logic [63:0]             win_s;
    logic [3:0]              c_s;
    logic [5:0]              shamt;

    assign push      = vld_q[READ_LATENCY-1];
    assign fifo_full = (cnt_q == (FIFO_LOG2+1)'(DEPTH));

    // Issue only when every outstanding read is guaranteed a FIFO slot.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + int'(vld_q[i]);
        end
        issue = ~ZBT_Busy_I & ~ZBT_Reset_Address_I
              & ((int'(cnt_q) + inflight) < DEPTH);
    end

    // Address pointer and latency-matched valid pipe.
    always_comb begin
        addr_d   = issue ? addr_q + ADDR_WIDTH'(1) : addr_q;
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        if (ZBT_Reset_Address_I) begin
            addr_d = '0;
            vld_d  = '0;
        end
    end

    // Window shift first, then refill from the FIFO when room for a word.
    always_comb begin
        shift = Shift_8_En_I & (c_q >= 4'd4);
        win_s = shift ? {win_q[55:0], 8'h00} : win_q;
        c_s   = c_q - {3'b000, shift};
        pop   = (c_s <= 4'd4) & (cnt_q != '0);
        shamt = 6'd32 - {c_s[2:0], 3'b000};
        win_d = win_s;
        c_d   = c_s;
        if (pop) begin
            win_d = win_s | ({32'h0, mem_q[rptr_q]} << shamt);
            c_d   = c_s + 4'd4;
        end
        if (ZBT_Reset_Address_I) begin
            pop   = 1'b0;
            win_d = '0;
            c_d   = '0;
        end
    end

    // FIFO pointers and occupancy; a restart flushes everything.
    always_comb begin
        wptr_d = wptr_q + (FIFO_LOG2)'(push);
        rptr_d = rptr_q + (FIFO_LOG2)'(pop);
        cnt_d  = cnt_q + (FIFO_LOG2+1)'(push) - (FIFO_LOG2+1)'(pop);
        if (ZBT_Reset_Address_I) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    // FIFO storage: returning read data lands here.
    always_ff @(posedge clock) begin
        if (!reset && !ZBT_Reset_Address_I && push) begin
            mem_q[wptr_q] <= ZBT_Data_I;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            vld_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            c_q     <= '0;
            empty_q <= 1'b1;
        end else begin
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            c_q     <= c_d;
            empty_q <= (c_d < 4'd4);
        end
    end

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset || ZBT_Reset_Address_I)
        !(push && fifo_full)
    );

    assign ZBT_Address_O    = addr_q;
    assign Buffer_Empty_O   = empty_q;
    assign Bitstream_Data_O = win_q[63:32];
    assign Word_Count_O     = cnt_q;

endmodule

// File: tb/tb_zbt_read_prefetch.sv
// Bench for zbt_read_prefetch: SRAM models, byte-stream reference model,
// directed scenarios plus randomized traffic.
module tb_zbt_read_prefetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        rst_addr;
    logic        busy;
    logic        shift;

    logic [18:0] addr;
    logic [31:0] data_i;
    logic        empty;
    logic [31:0] bdata;
    logic [2:0]  wcnt;

    logic [2:0]  waddr;
    logic [31:0] wdata_i;
    logic        wempty;
    logic [31:0] wbdata;
    logic [2:0]  wwcnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    zbt_read_prefetch u_dut (
        .clock               (clock),
        .reset               (reset),
        .ZBT_Reset_Address_I (rst_addr),
        .ZBT_Busy_I          (busy),
        .ZBT_Address_O       (addr),
        .ZBT_Data_I          (data_i),
        .Shift_8_En_I        (shift),
        .Buffer_Empty_O      (empty),
        .Bitstream_Data_O    (bdata),
        .Word_Count_O        (wcnt)
    );

    zbt_read_prefetch #(.ADDR_WIDTH(3)) u_wrap (
        .clock               (clock),
        .reset               (reset),
        .ZBT_Reset_Address_I (rst_addr),
        .ZBT_Busy_I          (busy),
        .ZBT_Address_O       (waddr),
        .ZBT_Data_I          (wdata_i),
        .Shift_8_En_I        (shift),
        .Buffer_Empty_O      (wempty),
        .Bitstream_Data_O    (wbdata),
        .Word_Count_O        (wwcnt)
    );

    // SRAM content: word a holds bytes 4a, 4a+1, 4a+2, 4a+3.
    function automatic logic [31:0] word_at(input int a);
        int b;
        b = 4 * a;
        return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
    endfunction

    // Expected window: stream bytes p..p+3 with addresses modulo 2^aw.
    function automatic logic [31:0] exp_win(input int p, input int aw);
        logic [31:0] r;
        int q;
        int a;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            q = p + k;
            a = (q / 4) % (1 << aw);
            r = {r[23:0], 8'(4 * a + q % 4)};
        end
        return r;
    endfunction

    // Two-cycle pipelined SRAMs driven by whatever address is on the bus.
    logic [18:0] a1, a2;
    logic [2:0]  wa1, wa2;
    always @(posedge clock) begin
        a1  <= addr;
        a2  <= a1;
        wa1 <= waddr;
        wa2 <= wa1;
    end
    assign data_i  = word_at(int'(a2));
    assign wdata_i = word_at(int'(wa2));

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Pulse the restart for one cycle; returns in the first cycle after it.
    task automatic restart();
        rst_addr = 1'b1;
        step();
        rst_addr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors += 4;
        if (addr !== 19'd0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", addr);
        end
        if (empty !== 1'b1) begin
            errors++; $display("FAIL reset_empty: got %b want 1", empty);
        end
        if (bdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", bdata);
        end
        if (wcnt !== 3'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", wcnt);
        end
        rst_addr = 1'b1;
        shift    = 1'b1;
        step();
        vectors += 2;
        if (addr !== 19'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_both: addr %h empty %b want 0/1",
                     addr, empty);
        end
        if (bdata !== 32'h0 || wcnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_both_data: data %h cnt %0d want 0/0",
                     bdata, wcnt);
        end
        rst_addr = 1'b0;
        shift    = 1'b0;
        reset    = 1'b0;
        step();
    endtask

    task automatic test_first_window();
        restart();
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (empty !== 1'b1) begin
                errors++;
                $display("FAIL latency_empty: cycle %0d got %b want 1",
                         i, empty);
            end
            step();
        end
        vectors++;
        if (empty !== 1'b0 || bdata !== 32'h00010203) begin
            errors++;
            $display("FAIL first_window: empty %b data %h want 0/00010203",
                     empty, bdata);
        end
        shift = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (empty !== 1'b0 || bdata !== exp_win(k, 19)) begin
                errors++;
                $display("FAIL shift_%0d: empty %b data %h want 0/%h",
                         k, empty, bdata, exp_win(k, 19));
            end
        end
        shift = 1'b0;
    endtask

    task automatic test_busy();
        restart();
        step();
        step();
        vectors++;
        if (addr !== 19'd2) begin
            errors++; $display("FAIL busy_pre_addr: got %h want 2", addr);
        end
        busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (addr !== 19'd2) begin
                errors++;
                $display("FAIL busy_hold: cycle %0d addr %h want 2",
                         i, addr);
            end
        end
        vectors++;
        if (empty !== 1'b0 || bdata !== 32'h00010203) begin
            errors++;
            $display("FAIL busy_landed: empty %b data %h want 0/00010203",
                     empty, bdata);
        end
        shift = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++;
            if (empty !== 1'b0 || bdata !== exp_win(k, 19)) begin
                errors++;
                $display("FAIL busy_shift_%0d: empty %b data %h want 0/%h",
                         k, empty, bdata, exp_win(k, 19));
            end
        end
        shift = 1'b0;
        busy  = 1'b0;
        step();
        vectors++;
        if (addr !== 19'd3) begin
            errors++; $display("FAIL busy_release: addr %h want 3", addr);
        end
    endtask

    task automatic test_no_shift();
        restart();
        for (int i = 0; i < 30; i++) step();
        vectors += 3;
        if (addr !== 19'd6) begin
            errors++; $display("FAIL fill_addr: got %h want 6", addr);
        end
        if (wcnt !== 3'd4) begin
            errors++; $display("FAIL fill_count: got %0d want 4", wcnt);
        end
        if (empty !== 1'b0 || bdata !== 32'h00010203) begin
            errors++;
            $display("FAIL fill_window: empty %b data %h want 0/00010203",
                     empty, bdata);
        end
        shift = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if (empty !== 1'b0 || bdata !== exp_win(k, 19)) begin
                errors++;
                $display("FAIL fill_drain_%0d: empty %b data %h want 0/%h",
                         k, empty, bdata, exp_win(k, 19));
            end
        end
        shift = 1'b0;
    endtask

    task automatic test_shift_while_empty();
        restart();
        shift = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (empty !== 1'b1 || bdata !== 32'h0) begin
                errors++;
                $display("FAIL empty_shift: cycle %0d empty %b data %h want 1/0",
                         i, empty, bdata);
            end
            if (i == 4) shift = 1'b0;
            step();
        end
        vectors++;
        if (empty !== 1'b0 || bdata !== 32'h00010203) begin
            errors++;
            $display("FAIL empty_shift_first: empty %b data %h want 0/00010203",
                     empty, bdata);
        end
    endtask

    task automatic test_restart_flush();
        restart();
        for (int i = 0; i < 5; i++) step();
        shift = 1'b1;
        step();
        step();
        shift    = 1'b1;
        rst_addr = 1'b1;
        step();
        rst_addr = 1'b0;
        shift    = 1'b0;
        vectors += 2;
        if (empty !== 1'b1 || wcnt !== 3'd0) begin
            errors++;
            $display("FAIL flush_state: empty %b cnt %0d want 1/0",
                     empty, wcnt);
        end
        if (addr !== 19'd0 || bdata !== 32'h0) begin
            errors++;
            $display("FAIL flush_addr: addr %h data %h want 0/0",
                     addr, bdata);
        end
        for (int i = 0; i < 4; i++) step();
        shift = 1'b1;
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if (empty !== 1'b0 || bdata !== exp_win(k, 19)) begin
                errors++;
                $display("FAIL flush_stream_%0d: empty %b data %h want 0/%h",
                         k, empty, bdata, exp_win(k, 19));
            end
            step();
        end
        shift = 1'b0;
    endtask

    task automatic test_back_to_back();
        restart();
        for (int i = 0; i < 4; i++) step();
        shift = 1'b1;
        for (int k = 0; k < 60; k++) begin
            vectors++;
            if (empty !== 1'b0 || bdata !== exp_win(k, 19)) begin
                errors++;
                $display("FAIL b2b_%0d: empty %b data %h want 0/%h",
                         k, empty, bdata, exp_win(k, 19));
            end
            step();
        end
        shift = 1'b0;
    endtask

    task automatic test_wrap();
        int pw;
        int pm;
        bit saw_wrap;
        logic [2:0] prev;
        pw = 0;
        pm = 0;
        saw_wrap = 1'b0;
        restart();
        prev  = waddr;
        shift = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (waddr !== prev) begin
                vectors++;
                if (waddr !== prev + 3'd1) begin
                    errors++;
                    $display("FAIL wrap_addr: %0d -> %0d", prev, waddr);
                end
                if (prev == 3'd7 && waddr == 3'd0) saw_wrap = 1'b1;
            end
            prev = waddr;
            if (!wempty) begin
                vectors++;
                if (wbdata !== exp_win(pw, 3)) begin
                    errors++;
                    $display("FAIL wrap_stream_%0d: got %h want %h",
                             pw, wbdata, exp_win(pw, 3));
                end
                pw++;
            end
            if (!empty) begin
                vectors++;
                if (bdata !== exp_win(pm, 19)) begin
                    errors++;
                    $display("FAIL wide_stream_%0d: got %h want %h",
                             pm, bdata, exp_win(pm, 19));
                end
                pm++;
            end
            step();
        end
        shift = 1'b0;
        vectors++;
        if (!saw_wrap || pw < 40) begin
            errors++;
            $display("FAIL wrap_seen: wrapped %0d bytes %0d want 1/>=40",
                     saw_wrap, pw);
        end
    endtask

    task automatic test_random();
        int p;
        int total;
        logic [18:0] prev_addr;
        bit prev_busy;
        bit prev_rst;
        restart();
        p = 0;
        total = 0;
        prev_addr = addr;
        prev_busy = 1'b0;
        prev_rst  = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (prev_rst) begin
                vectors++;
                if (empty !== 1'b1 || addr !== 19'd0) begin
                    errors++;
                    $display("FAIL rnd_restart: empty %b addr %h want 1/0",
                             empty, addr);
                end
            end else if (addr !== prev_addr) begin
                vectors++;
                if (prev_busy || addr !== prev_addr + 19'd1) begin
                    errors++;
                    $display("FAIL rnd_addr: %h -> %h busy %0d",
                             prev_addr, addr, prev_busy);
                end
            end
            if (!empty) begin
                vectors++;
                if (bdata !== exp_win(p, 19)) begin
                    errors++;
                    $display("FAIL rnd_stream_%0d: got %h want %h",
                             p, bdata, exp_win(p, 19));
                end
            end
            if (wcnt > 3'd4) begin
                vectors++;
                errors++;
                $display("FAIL rnd_count: got %0d want <=4", wcnt);
            end
            prev_addr = addr;
            busy     = ($urandom_range(0, 99) < 30);
            shift    = ($urandom_range(0, 99) < 60);
            rst_addr = ($urandom_range(0, 99) < 2);
            prev_busy = busy;
            prev_rst  = rst_addr;
            if (rst_addr) begin
                p = 0;
            end else if (shift && !empty) begin
                p++;
                total++;
            end
            step();
        end
        busy = 1'b0;
        shift = 1'b0;
        rst_addr = 1'b0;
        vectors++;
        if (total < 200) begin
            errors++;
            $display("FAIL rnd_throughput: got %0d bytes want >=200", total);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rst_addr = 1'b0;
        busy     = 1'b0;
        shift    = 1'b0;
        test_reset();
        test_first_window();
        test_busy();
        test_no_shift();
        test_shift_while_empty();
        test_restart_flush();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/zbt_read_prefetch.md
Name: zbt_read_prefetch

Overview:
- Read-side stage between the ZBT bitstream ring buffer and the system-stream parser.
- Issues 32-bit ZBT reads whenever the Ethernet writer does not own the bus, and absorbs the pipelined SRAM read latency with a small word FIFO.
- Presents the stream to the parser as a 32-bit byte-aligned window that advances 8 bits per shift request.

Parameters:
- ADDR_WIDTH, 19, ZBT word-address width; the address wraps modulo 2^ADDR_WIDTH.
- FIFO_LOG2, 2, log2 of word FIFO depth (default 4 words).
- READ_LATENCY, 2, cycles from address issue to ZBT_Data_I valid.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ZBT_Reset_Address_I  in  1  synchronous restart: read pointer to 0, flush all buffered data.
- ZBT_Busy_I  in  1  writer owns ZBT this cycle; no read may be issued.
- ZBT_Address_O  out  ADDR_WIDTH  read word address.
- ZBT_Data_I  in  32  ZBT read data, big-endian (bits 31:24 = first byte).
- Shift_8_En_I  in  1  consume one byte from the window.
- Buffer_Empty_O  out  1  window holds fewer than 4 valid bytes.
- Bitstream_Data_O  out  32  next 4 stream bytes, oldest in bits 31:24.
- Word_Count_O  out  FIFO_LOG2+1  FIFO occupancy, for debug.

Behaviour:

Reset (reset=1):
- ZBT_Address_O=0, FIFO empty, in-flight pipe cleared.
- 64-bit window register cleared, byte count=0.
- Buffer_Empty_O=1, Bitstream_Data_O=0, Word_Count_O=0.

Read issue:
- issue = ~ZBT_Busy_I & ~ZBT_Reset_Address_I & (occupancy + inflight < 2^FIFO_LOG2).
- inflight = popcount of the READ_LATENCY-deep valid shift register.
- On issue, the current ZBT_Address_O is the read address. The address increments the next cycle and wraps from 2^ADDR_WIDTH-1 to 0.
- ZBT_Address_O holds its value while not issuing.

Return path:
- Valid pipe shifts every cycle, independent of ZBT_Busy_I: a read issued before the writer took the bus still returns.
- When the pipe output is 1, ZBT_Data_I is written into the FIFO.
- The issue rule guarantees the FIFO never overflows; a write into a full FIFO is an assertion failure.

Window:
- 64-bit register W with byte count C in 0..8. Bitstream_Data_O = W[63:32].
- Buffer_Empty_O = (C<4), registered from the next-state C.

Per-cycle order:
1. If Shift_8_En_I & C>=4: W<<=8, C-=1. A shift while Buffer_Empty_O=1 is ignored with no state change.
2. Then, if the post-shift C<=4 and the FIFO is non-empty: pop one word into bytes [C..C+3] counted from the MSB, C+=4.
- Shift and refill in the same cycle are legal; throughput is 1 byte/cycle sustained.
- FIFO push and pop in the same cycle are legal; occupancy is unchanged.

Latency:
- Restart to first Buffer_Empty_O=0 is 1 + READ_LATENCY + 2 cycles when ZBT_Busy_I=0.

ZBT_Reset_Address_I=1:
- Same cycle effect on the next edge: address to 0, FIFO flushed, valid pipe cleared (in-flight returns dropped), C=0, W=0, Buffer_Empty_O=1.
- No issue occurs during the cycle in which it is asserted.
- Shift_8_En_I is ignored in that cycle.

Simultaneous reset and ZBT_Reset_Address_I:
- Same result as reset alone.

Test Plan:
1. Reset then restart with ZBT_Busy_I=0; SRAM model with words 0x00010203, 0x04050607, latency 2:
   - Buffer_Empty_O falls at cycle 5 with Bitstream_Data_O=0x00010203.
   - Four shifts on consecutive cycles give 0x01020304, 0x02030405, 0x03040506, 0x04050607; Buffer_Empty_O stays 0.
2. Hold ZBT_Busy_I=1 for 10 cycles after two reads are issued:
   - Both words still land in the FIFO.
   - ZBT_Address_O stays at 2.
   - No new issue until busy drops.
3. Never shift:
   - Issues stop after FIFO + window fill: Word_Count_O=4, C=8 with 6 reads in total, ZBT_Address_O=6.
   - No overflow assertion fires.
4. Start the address at 2^19-2 via a preloaded model:
   - Reads hit 0x7FFFE, 0x7FFFF, 0x00000 in order and the byte stream is continuous.
5. Assert ZBT_Reset_Address_I with 2 reads in flight and C=6:
   - Next cycle C=0, Buffer_Empty_O=1, Word_Count_O=0.
   - The dropped returns never appear in the stream.
   - The first new output is the word at address 0.
6. Pulse Shift_8_En_I while Buffer_Empty_O=1:
   - W, C and Bitstream_Data_O are unchanged.
   - The first valid window still starts at byte 0x00.
